seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
//  Multiplexed 4-digit hex driver for the Basys3/Nexys A7 common-anode 7-segment display.
//  Sits downstream of the user design in the FPGA top level and replaces the fixed single-digit drive (an=1110).
//  Takes a 16-bit value plus 4 decimal points, hex-decodes each nibble and scans the digits.
//  Includes anti-ghosting blanking and a tear-free frame-boundary update.
// PARAMETERS
//  REFRESH_DIV   50000  clock cycles per digit slot (100 MHz -> 2 kHz/digit, 500 Hz frame); must be >= 2
//  BLANK_CYCLES  1000   cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
// PORTS
//  clock   in   1   system clock
//  reset   in   1   synchronous, active-high reset
//  value   in   16  hex value; value[3:0] -> rightmost digit (an[0]), value[15:12] -> an[3]
//  dp_in   in   4   decimal point per digit, active high; dp_in[i] belongs to digit i
//  load    in   1   strobe: capture value/dp_in into the pending register
//  seg     out  7   segments a..g on seg[0]..seg[6], active low
//  dp      out  1   decimal point, active low
//  an      out  4   digit anodes, active low
//  frame   out  1   one-cycle pulse at each frame boundary (digit 3 -> 0 wrap)
// BEHAVIOUR
//  - Reset: slot counter=0, digit=0, pending=0, shadow=0; seg=7'h7F, dp=1, an=4'hF, frame=0.
//  - Slot counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit advances 0->1->2->3->0.
//  - Frame boundary = the cycle in which the counter wraps while digit==3.
//    At the boundary: shadow <= (load ? {dp_in,value} : pending). frame=1 for that cycle only.
//  - load=1 in any cycle: pending <= {dp_in,value}. The last load before the boundary wins.
//    A load coinciding with the boundary is visible in the frame that starts immediately.
//  - Display is driven only from shadow, never from value directly, so no digit mixes old and new data.
//  - All outputs are registered and lag the internal counter/digit state by 1 cycle.
//  - Counter < BLANK_CYCLES: an=4'hF, seg=7'h7F, dp=1.
//    Otherwise: an=~(4'b0001<<digit), seg=hex(shadow nibble[digit]), dp=~shadow_dp[digit].
//  - Hex table (g..a, active low):
//      0=1000000  1=1111001  2=0100100  3=0110000  4=0011001  5=0010010  6=0000010  7=1111000
//      8=0000000  9=0010000  A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//  - At most one anode is low in any cycle. an never changes directly from one digit to another without >= 1 all-off cycle.
//  - Reset asserted mid-scan: all state returns to reset values on the next edge; no frame pulse during reset.
//  - Counter width is $clog2(REFRESH_DIV); the wrap compare uses REFRESH_DIV-1 exactly (no power-of-2 rounding).
// CONFIGURATION
//  SEG7_LZ_BLANK_EN defined: leading-zero blanking.
//    Digit i (i=3..1) is blanked (seg=7'h7F, anode still follows scan) when nibbles i..3 of shadow are all zero.
//    Its dp still follows dp_in. Digit 0 is always shown.
//  SEG7_LZ_BLANK_EN undefined: all four digits always show their hex nibble, including leading zeros.
// TESTING (bench params REFRESH_DIV=8, BLANK_CYCLES=2)
//  1. Reset held 3 cycles, release, no load.
//     -> an=F for counter 0..1, then an=E with seg=1000000 (0); frame pulses every 32 cycles.
//  2. load value=16'h12AF, dp_in=0 mid-frame.
//     -> display unchanged until the next frame pulse. Then:
//        an=E seg=0001110, an=D seg=0001000, an=B seg=0100100, an=7 seg=1111001.
//  3. load 16'h1111 then 16'h2222 in the same frame.
//     -> next frame shows only 2222. A load asserted exactly in the frame-pulse cycle shows in the frame just starting.
//  4. Check every cycle over 4 frames.
//     -> popcount(~an)<=1; between consecutive different anode codes, an=F for exactly 2 cycles.
//  5. dp_in=4'b0100, value=16'h8888.
//     -> dp=0 only while an=B; seg=0000000 on all digits.
//  6. SEG7_LZ_BLANK_EN, value=16'h0005.
//     -> digits 3..1 seg=7F, digit 0 seg=0010010; without the macro, digits 3..1 show 1000000.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 4-digit hex driver for a common-anode 7-segment display
//
// Purpose: hex-decodes a 16-bit value (plus 4 decimal points) and scans it onto
// four common-anode digits. Each digit slot starts with an all-off blanking window
// to prevent ghosting. New data is taken only at frame boundaries, so every frame
// shows a single consistent value.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   value  - hex value; value[3:0] -> an[0] (rightmost), value[15:12] -> an[3]
//   dp_in  - decimal point per digit, active high; dp_in[i] -> digit i
//   load   - strobe: capture {dp_in, value} into the pending register
//   seg    - segments a..g on seg[0]..seg[6], active low
//   dp     - decimal point, active low
//   an     - digit anodes, active low
//   frame  - one-cycle pulse at each frame boundary (digit 3 -> 0 wrap)
//
// Optional feature: define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [19:0]   pending;   // {dp[3:0], value[15:0]} awaiting the next frame
  logic [19:0]   shadow;    // {dp[3:0], value[15:0]} being displayed

  logic          wrap;
  logic          boundary;
  logic [19:0]   captured;
  logic [3:0]    nib;
  logic [3:0]    shadow_dp;
  logic [3:0]    lz;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    an_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    // Returned as {g,f,e,d,c,b,a}, active low.
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    wrap      = (cnt == LAST);
    boundary  = wrap && (digit == 2'd3);
    captured  = {dp_in, value};
    nib       = shadow[{digit, 2'b00} +: 4];
    shadow_dp = shadow[19:16];

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    lz[3] = (shadow[15:12] == 4'h0);
    lz[2] = lz[3] && (shadow[11:8] == 4'h0);
    lz[1] = lz[2] && (shadow[7:4] == 4'h0);
    lz[0] = 1'b0;
`else
    lz = 4'b0000;
`endif

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    // The blanking window at the start of every slot guarantees an all-off gap
    // between two different anode codes.
    if (cnt >= BLANK_END) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = lz[digit] ? 7'h7F : hex7(nib);
      dp_d  = ~shadow_dp[digit];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      digit   <= 2'd0;
      pending <= 20'd0;
      shadow  <= 20'd0;
      seg     <= 7'h7F;
      dp      <= 1'b1;
      an      <= 4'hF;
      frame   <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) begin
        digit <= digit + 2'd1;
      end
      if (load) begin
        pending <= captured;
      end
      // A load landing on the boundary cycle bypasses pending so it shows in
      // the frame starting right now.
      if (boundary) begin
        shadow <= load ? captured : pending;
      end
      seg   <= seg_d;
      dp    <= dp_d;
      an    <= an_d;
      frame <= boundary;
    end
  end

endmodule
